micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Microprogram sequencer that sits directly downstream of the status register.
- Consumes the V, Z, S, C flags and the branch fields of the current microinstruction, and produces the next control address register (CAR) value for the control memory.
- Supports sequential step, conditional jump, conditional subroutine call/return through a small LIFO stack, and opcode mapping.

Parameters:
ADDR_W, 7, width of the control address (control memory of 2^ADDR_W words)
STACK_DEPTH, 4, number of return-address entries in the subroutine stack (1..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
en  input  1  advance enable; when low all state holds
V  input  1  overflow flag from status register
Z  input  1  zero flag from status register
S  input  1  sign flag from status register
C  input  1  carry flag from status register
cond_sel  input  3  condition select field of current microinstruction
br_type  input  2  branch type field: 00 JMP, 01 CALL, 10 RET, 11 MAP
br_addr  input  ADDR_W  branch/call target address field
map_addr  input  ADDR_W  mapped address derived from the instruction opcode
car  output  ADDR_W  control address register (registered)
sp  output  4  current stack occupancy, 0..STACK_DEPTH (registered)
stack_err  output  1  sticky error: overflow or underflow occurred (registered)

Behaviour:
- Reset:
  - rst_n low at a rising edge sets car=0, sp=0, stack_err=0 and clears all stack entries to 0.
  - Reset overrides en and all other inputs. Mid-operation reset discards any pending call/return.
- Hold: en=0 leaves car, sp, stack contents and stack_err unchanged.
- Condition decode is combinational from the flags and cond_sel in the same cycle. Flags must be stable before the edge.
  - cond_sel: 0 true, 1 Z, 2 !Z, 3 C, 4 !C, 5 S, 6 V, 7 S^V (signed less-than).
- Increment: inc = car+1, modulo 2^ADDR_W (all-ones wraps to 0).
- Next-state rules, applied at a rising edge with en=1:
  - JMP (00): cond true -> car<=br_addr; false -> car<=inc.
  - CALL (01), cond true and sp<STACK_DEPTH -> push inc to stack[sp], sp<=sp+1, car<=br_addr.
  - CALL (01), cond true and sp==STACK_DEPTH (full) -> no push, sp unchanged, car<=inc, stack_err<=1.
  - CALL (01), cond false -> car<=inc, stack untouched.
  - RET (10), cond true and sp>0 -> car<=stack[sp-1], sp<=sp-1.
  - RET (10), cond true and sp==0 (empty) -> car<=inc, stack_err<=1.
  - RET (10), cond false -> car<=inc.
  - MAP (11): car<=map_addr unconditionally. cond_sel is ignored and the stack is untouched.
- Latency: one cycle. The decision made from inputs at edge N is visible on car after edge N.
- stack_err stays set until reset. It has no other effect on sequencing.
- No simultaneous push and pop: exactly one br_type per cycle.

Test Plan:
- Reset with en=1 and arbitrary inputs -> car=0, sp=0, stack_err=0. Sequential steps: JMP with cond_sel=2 and Z=1 for 3 cycles -> car 1,2,3.
- car=0x10, JMP cond_sel=3, C=1, br_addr=0x40 -> car=0x40. Same with C=0 -> car=0x11. cond_sel=7 with S=1, V=0 -> taken; with S=1, V=1 -> not taken.
- CALL cond_sel=0 from car=0x05 to 0x20, then CALL from 0x20 to 0x30, then RET twice (cond 0) -> car 0x20, 0x30, 0x21, 0x06; sp 1, 2, 1, 0.
- STACK_DEPTH=4: 5 CALLs taken -> fifth gives car=inc, sp=4, stack_err=1. Then RET on empty stack after 4 pops -> car=inc, stack_err stays 1.
- car=0x7F (ADDR_W=7), JMP cond not taken -> car=0x00. MAP with map_addr=0x3A and cond_sel=1, Z=0 -> car=0x3A.
- en=0 for 3 cycles with CALL asserted -> car, sp, stack unchanged. Assert rst_n=0 at sp=2 -> car=0, sp=0; a following RET -> stack_err=1.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: computes the next control address register (CAR) value from the
// status flags and the branch fields of the current microinstruction.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset (clears CAR, stack pointer, error flag, stack)
//   en         - advance enable; when low all state holds
//   V, Z, S, C - overflow, zero, sign and carry flags from the status register
//   cond_sel   - condition select: 0 true, 1 Z, 2 !Z, 3 C, 4 !C, 5 S, 6 V, 7 S^V
//   br_type    - 00 JMP, 01 CALL, 10 RET, 11 MAP
//   br_addr    - jump/call target address
//   map_addr   - address mapped from the instruction opcode
//   car        - control address register
//   sp         - return stack occupancy, 0..STACK_DEPTH
//   stack_err  - sticky flag: a taken CALL hit a full stack or a taken RET hit an empty one
module micro_sequencer #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              V,
  input  logic              Z,
  input  logic              S,
  input  logic              C,
  input  logic [2:0]        cond_sel,
  input  logic [1:0]        br_type,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic [ADDR_W-1:0] map_addr,
  output logic [ADDR_W-1:0] car,
  output logic [3:0]        sp,
  output logic              stack_err
);

  localparam logic [1:0] BrJmp  = 2'b00;
  localparam logic [1:0] BrCall = 2'b01;
  localparam logic [1:0] BrRet  = 2'b10;
  localparam logic [1:0] BrMap  = 2'b11;

  localparam logic [3:0]        SpFull  = 4'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  logic [ADDR_W-1:0] car_q, car_d;
  logic [3:0]        sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic              cond;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] ret_addr;

  always_comb begin
    cond = 1'b1;
    case (cond_sel)
      3'd0:    cond = 1'b1;
      3'd1:    cond = Z;
      3'd2:    cond = ~Z;
      3'd3:    cond = C;
      3'd4:    cond = ~C;
      3'd5:    cond = S;
      3'd6:    cond = V;
      default: cond = S ^ V;  // signed less-than
    endcase
  end

  assign inc = car_q + AddrOne;  // wraps modulo 2^ADDR_W

  // Top-of-stack entry (stack[sp-1]); only meaningful when sp > 0.
  always_comb begin
    ret_addr = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (4'(i) + 4'd1 == sp_q) ret_addr = stack_q[i];
    end
  end

  always_comb begin
    car_d   = car_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (en) begin
      unique case (br_type)
        BrJmp: car_d = cond ? br_addr : inc;
        BrCall: begin
          if (!cond) begin
            car_d = inc;
          end else if (sp_q < SpFull) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
              if (4'(i) == sp_q) stack_d[i] = inc;
            end
            sp_d  = sp_q + 4'd1;
            car_d = br_addr;
          end else begin
            // Overflow: fall through sequentially and flag it.
            car_d = inc;
            err_d = 1'b1;
          end
        end
        BrRet: begin
          if (!cond) begin
            car_d = inc;
          end else if (sp_q != 4'd0) begin
            sp_d  = sp_q - 4'd1;
            car_d = ret_addr;
          end else begin
            car_d = inc;
            err_d = 1'b1;
          end
        end
        BrMap: car_d = map_addr;
        default: car_d = car_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      car_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      car_q   <= car_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign car       = car_q;
  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer. Every applied cycle pushes the model's expected
// {car, sp, stack_err} onto a scoreboard queue; the scenario task pops and compares it after
// the edge, and additionally checks hand-derived constants where a row carries one.
module tb_micro_sequencer;

  localparam int AW    = 7;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic          rst_n;
    logic          en;
    logic [1:0]    bt;
    logic [2:0]    cs;
    logic [3:0]    f;     // {V, Z, S, C}
    logic [AW-1:0] ba;
    logic [AW-1:0] ma;
    logic [11:0]   want;  // {car, sp, stack_err}
    logic          chk;
  } stim_t;

  logic          clk = 1'b0;
  logic          rst_n, en, V, Z, S, C;
  logic [2:0]    cond_sel;
  logic [1:0]    br_type;
  logic [AW-1:0] br_addr, map_addr, car;
  logic [3:0]    sp;
  logic          stack_err;

  int checks = 0;
  int errors = 0;

  logic [11:0]   sb[$];
  logic [AW-1:0] m_car;
  logic [3:0]    m_sp;
  logic          m_err;
  logic [AW-1:0] m_stack [DEPTH];

  always #5 clk = ~clk;

  micro_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .V(V), .Z(Z), .S(S), .C(C),
    .cond_sel(cond_sel), .br_type(br_type), .br_addr(br_addr), .map_addr(map_addr),
    .car(car), .sp(sp), .stack_err(stack_err)
  );

  function automatic stim_t mk(logic r, logic e, logic [1:0] bt, logic [2:0] cs, logic [3:0] f,
                               logic [AW-1:0] ba, logic [AW-1:0] ma, logic [AW-1:0] wc,
                               logic [3:0] ws, logic we, logic chk);
    stim_t s;
    s.rst_n = r; s.en = e; s.bt = bt; s.cs = cs; s.f = f; s.ba = ba; s.ma = ma;
    s.want = {wc, ws, we}; s.chk = chk;
    return s;
  endfunction

  function automatic logic cond_of(logic [2:0] cs, logic [3:0] f);
    case (cs)
      3'd0: return 1'b1;
      3'd1: return f[2];
      3'd2: return ~f[2];
      3'd3: return f[0];
      3'd4: return ~f[0];
      3'd5: return f[1];
      3'd6: return f[3];
      default: return f[1] ^ f[3];
    endcase
  endfunction

  // Drive one cycle, update the reference model, queue its expectation, and wait past the edge.
  task automatic drive(input stim_t r);
    logic          c;
    logic [AW-1:0] nxt;
    @(negedge clk);
    rst_n = r.rst_n; en = r.en; br_type = r.bt; cond_sel = r.cs;
    {V, Z, S, C} = r.f; br_addr = r.ba; map_addr = r.ma;
    if (!r.rst_n) begin
      m_car = '0; m_sp = '0; m_err = 1'b0;
      foreach (m_stack[k]) m_stack[k] = '0;
    end else if (r.en) begin
      c   = cond_of(r.cs, r.f);
      nxt = m_car + 7'd1;
      case (r.bt)
        2'd0: m_car = c ? r.ba : nxt;
        2'd1: begin
          if (c && m_sp < 4'(DEPTH)) begin
            m_stack[m_sp] = nxt; m_sp = m_sp + 4'd1; m_car = r.ba;
          end else begin
            if (c) m_err = 1'b1;
            m_car = nxt;
          end
        end
        2'd2: begin
          if (c && m_sp > 4'd0) begin
            m_sp = m_sp - 4'd1; m_car = m_stack[m_sp];
          end else begin
            if (c) m_err = 1'b1;
            m_car = nxt;
          end
        end
        default: m_car = r.ma;
      endcase
    end
    sb.push_back({m_car, m_sp, m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    stim_t rows[$];
    logic [11:0] e, got;
    rows.push_back(mk(1'b0, 1'b1, 2'd1, 3'd0, 4'hF, 7'h55, 7'h2A, 7'h00, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b0, 1'b0, 2'd3, 3'd7, 4'h5, 7'h11, 7'h22, 7'h00, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd2, 4'h4, 7'h7E, 7'h00, 7'h01, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd2, 4'h4, 7'h7E, 7'h00, 7'h02, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd2, 4'h4, 7'h7E, 7'h00, 7'h03, 4'd0, 1'b0, 1'b1));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); got = {car, sp, stack_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_model[%0d] got car=%h sp=%0d err=%b want car=%h sp=%0d err=%b",
                 i, got[11:5], got[4:1], got[0], e[11:5], e[4:1], e[0]);
      end
      if (rows[i].chk) begin
        checks++;
        if (got !== rows[i].want) begin
          errors++;
          $display("FAIL reset_const[%0d] got %h want %h", i, got, rows[i].want);
        end
      end
    end
  endtask

  task automatic test_jump;
    stim_t rows[$];
    logic [11:0] e, got;
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd0, 4'h0, 7'h10, 7'h00, 7'h10, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd3, 4'h1, 7'h40, 7'h00, 7'h40, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd0, 4'h0, 7'h10, 7'h00, 7'h10, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd3, 4'h0, 7'h40, 7'h00, 7'h11, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd7, 4'h2, 7'h55, 7'h00, 7'h55, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd7, 4'hA, 7'h22, 7'h00, 7'h56, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd4, 4'h0, 7'h33, 7'h00, 7'h33, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd6, 4'h7, 7'h08, 7'h00, 7'h34, 4'd0, 1'b0, 1'b1));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); got = {car, sp, stack_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL jump_model[%0d] got car=%h sp=%0d err=%b want car=%h sp=%0d err=%b",
                 i, got[11:5], got[4:1], got[0], e[11:5], e[4:1], e[0]);
      end
      if (rows[i].chk) begin
        checks++;
        if (got !== rows[i].want) begin
          errors++;
          $display("FAIL jump_const[%0d] got %h want %h", i, got, rows[i].want);
        end
      end
    end
  endtask

  task automatic test_call_ret;
    stim_t rows[$];
    logic [11:0] e, got;
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd0, 4'h0, 7'h05, 7'h00, 7'h05, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h20, 7'h00, 7'h20, 4'd1, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h30, 7'h00, 7'h30, 4'd2, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h77, 7'h00, 7'h21, 4'd1, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h77, 7'h00, 7'h06, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd1, 4'h0, 7'h70, 7'h00, 7'h07, 4'd0, 1'b0, 1'b1));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); got = {car, sp, stack_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL callret_model[%0d] got car=%h sp=%0d err=%b want car=%h sp=%0d err=%b",
                 i, got[11:5], got[4:1], got[0], e[11:5], e[4:1], e[0]);
      end
      if (rows[i].chk) begin
        checks++;
        if (got !== rows[i].want) begin
          errors++;
          $display("FAIL callret_const[%0d] got %h want %h", i, got, rows[i].want);
        end
      end
    end
  endtask

  // Starts from car=0x07, sp=0, stack_err=0.
  task automatic test_stack_errors;
    stim_t rows[$];
    logic [11:0] e, got;
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h10, 7'h00, 7'h10, 4'd1, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h20, 7'h00, 7'h20, 4'd2, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h30, 7'h00, 7'h30, 4'd3, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h40, 7'h00, 7'h40, 4'd4, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h50, 7'h00, 7'h41, 4'd4, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h00, 7'h00, 7'h31, 4'd3, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h00, 7'h00, 7'h21, 4'd2, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h00, 7'h00, 7'h11, 4'd1, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h00, 7'h00, 7'h08, 4'd0, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h00, 7'h00, 7'h09, 4'd0, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd1, 4'h0, 7'h00, 7'h00, 7'h0A, 4'd0, 1'b1, 1'b1));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); got = {car, sp, stack_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stackerr_model[%0d] got car=%h sp=%0d err=%b want car=%h sp=%0d err=%b",
                 i, got[11:5], got[4:1], got[0], e[11:5], e[4:1], e[0]);
      end
      if (rows[i].chk) begin
        checks++;
        if (got !== rows[i].want) begin
          errors++;
          $display("FAIL stackerr_const[%0d] got %h want %h", i, got, rows[i].want);
        end
      end
    end
  endtask

  // stack_err is still set from the previous scenario.
  task automatic test_wrap_map;
    stim_t rows[$];
    logic [11:0] e, got;
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd0, 4'h0, 7'h7F, 7'h00, 7'h7F, 4'd0, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd0, 3'd1, 4'h0, 7'h15, 7'h00, 7'h00, 4'd0, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd3, 3'd1, 4'h0, 7'h11, 7'h3A, 7'h3A, 4'd0, 1'b1, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd3, 3'd0, 4'hF, 7'h11, 7'h65, 7'h65, 4'd0, 1'b1, 1'b1));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); got = {car, sp, stack_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wrapmap_model[%0d] got car=%h sp=%0d err=%b want car=%h sp=%0d err=%b",
                 i, got[11:5], got[4:1], got[0], e[11:5], e[4:1], e[0]);
      end
      if (rows[i].chk) begin
        checks++;
        if (got !== rows[i].want) begin
          errors++;
          $display("FAIL wrapmap_const[%0d] got %h want %h", i, got, rows[i].want);
        end
      end
    end
  endtask

  task automatic test_hold_reset;
    stim_t rows[$];
    logic [11:0] e, got;
    rows.push_back(mk(1'b0, 1'b1, 2'd0, 3'd0, 4'h0, 7'h00, 7'h00, 7'h00, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h12, 7'h00, 7'h12, 4'd1, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h34, 7'h00, 7'h34, 4'd2, 1'b0, 1'b1));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(1'b1, 1'b0, 2'd1, 3'd0, 4'h0, 7'h56, 7'h00, 7'h34, 4'd2, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h00, 7'h00, 7'h13, 4'd1, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd1, 3'd0, 4'h0, 7'h44, 7'h00, 7'h44, 4'd2, 1'b0, 1'b1));
    rows.push_back(mk(1'b0, 1'b1, 2'd2, 3'd0, 4'h0, 7'h00, 7'h00, 7'h00, 4'd0, 1'b0, 1'b1));
    rows.push_back(mk(1'b1, 1'b1, 2'd2, 3'd0, 4'h0, 7'h00, 7'h00, 7'h01, 4'd0, 1'b1, 1'b1));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); got = {car, sp, stack_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL holdrst_model[%0d] got car=%h sp=%0d err=%b want car=%h sp=%0d err=%b",
                 i, got[11:5], got[4:1], got[0], e[11:5], e[4:1], e[0]);
      end
      if (rows[i].chk) begin
        checks++;
        if (got !== rows[i].want) begin
          errors++;
          $display("FAIL holdrst_const[%0d] got %h want %h", i, got, rows[i].want);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    stim_t r;
    logic [11:0] e, got;
    for (int i = 0; i < 300; i++) begin
      r.rst_n = ($urandom_range(59) != 0);
      r.en    = ($urandom_range(9) != 0);
      r.bt    = 2'($urandom_range(3));
      r.cs    = 3'($urandom_range(7));
      r.f     = 4'($urandom_range(15));
      r.ba    = 7'($urandom_range(127));
      r.ma    = 7'($urandom_range(127));
      r.want  = '0;
      r.chk   = 1'b0;
      drive(r);
      e = sb.pop_front(); got = {car, sp, stack_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL random[%0d] got car=%h sp=%0d err=%b want car=%h sp=%0d err=%b",
                 i, got[11:5], got[4:1], got[0], e[11:5], e[4:1], e[0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; {V, Z, S, C} = 4'h0;
    cond_sel = '0; br_type = '0; br_addr = '0; map_addr = '0;
    test_reset();
    test_jump();
    test_call_ret();
    test_stack_errors();
    test_wrap_map();
    test_hold_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
